// File: rtl/cdc_handshake_tx.sv
// Source-side endpoint of a four-phase req/ack handshake across clock domains.
// Holds the accepted word stable on data_o while req_o is high and synchronizes ack_i locally.
module cdc_handshake_tx #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FLOP_NUMBER = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  done_o
);

  // state   | meaning
  // IDLE    | ready for a new word; a synchronized ack seen here is stale and ignored
  // REQ     | req_o high, waiting for the synchronized ack to rise
  // RELEASE | req_o low, waiting for the synchronized ack to fall before closing
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [FLOP_NUMBER-1:0]  ack_sync_q, ack_sync_d;
  logic                    ack_s;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;

  generate
    if (FLOP_NUMBER < 2) begin : g_bad_flop_number
      $error("cdc_handshake_tx: FLOP_NUMBER must be at least 2");
    end
  endgenerate

  // ack_i is asynchronous; nothing but the first stage of this chain may observe it.
  always_comb begin
    ack_sync_d = {ack_sync_q[FLOP_NUMBER-2:0], ack_i};
  end

  assign ack_s = ack_sync_q[FLOP_NUMBER-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (valid_i) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        req_d = 1'b1;
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        req_d = 1'b0;
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign req_o   = req_q;
  assign data_o  = data_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with FLOP_NUMBER=2 and ack_i driven synchronously.
module tb_cdc_handshake_tx;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        req_o;
  logic [31:0] data_o;
  logic        ack_i;
  logic        done_o;

  int checks   = 0;
  int failures = 0;

  cdc_handshake_tx #(
    .DATA_WIDTH (32),
    .FLOP_NUMBER(2)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .valid_i(valid_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .req_o  (req_o),
    .data_o (data_o),
    .ack_i  (ack_i),
    .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ack;
    logic        exp_ready;
    logic        exp_req;
    logic        exp_done;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (req_o !== level && n < budget) begin
      step();
      n++;
    end
    chk(name, {63'd0, req_o}, {63'd0, level});
  endtask

  initial begin
    int done_cnt;
    int bad;

    // {valid, data, ack, exp_ready, exp_req, exp_done, exp_data}; expectations hold after each edge
    vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678};
    vecs[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678};
    vecs[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678};
    vecs[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[11] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[12] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[13] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678};
    vecs[14] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};

    rst_n_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ack_i   = 1'b0;
    #3;
    chk("reset_outputs", {60'd0, ready_o, req_o, done_o, 1'b0} | {32'd0, data_o},
        {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();

    // single transfer, back-pressure, acceptance on the done cycle, second transfer
    for (int i = 0; i < 15; i++) begin
      valid_i = vecs[i].valid;
      data_i  = vecs[i].data;
      ack_i   = vecs[i].ack;
      step();
      chk($sformatf("vec%0d", i), {29'd0, ready_o, req_o, done_o, data_o},
          {29'd0, vecs[i].exp_ready, vecs[i].exp_req, vecs[i].exp_done, vecs[i].exp_data});
    end

    // slow destination: 100 cycles without ack
    valid_i = 1'b1;
    data_i  = 32'hCAFEF00D;
    ack_i   = 1'b0;
    step();
    valid_i = 1'b1;
    data_i  = 32'h0BADF00D;
    chk("slow_accept_req", {63'd0, req_o}, 64'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (req_o !== 1'b1 || ready_o !== 1'b0 || data_o !== 32'hCAFEF00D || done_o !== 1'b0) bad++;
    end
    chk("slow_hold_bad_cycles", 64'(bad), 64'd0);
    valid_i = 1'b0;
    ack_i   = 1'b1;
    wait_req(1'b0, 10, "slow_req_fall");
    ack_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done_o === 1'b1) done_cnt++;
    end
    chk("slow_done_count", 64'(done_cnt), 64'd1);
    chk("slow_ready", {63'd0, ready_o}, 64'd1);

    // spurious acknowledge while idle
    bad = 0;
    ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (req_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b1) bad++;
    end
    ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (req_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b1) bad++;
    end
    chk("spurious_bad_cycles", 64'(bad), 64'd0);
    chk("spurious_data", {32'd0, data_o}, {32'd0, 32'hCAFEF00D});

    // reset while in RELEASE
    valid_i = 1'b1;
    data_i  = 32'h11112222;
    step();
    valid_i = 1'b0;
    ack_i   = 1'b1;
    wait_req(1'b0, 10, "rst_reach_release");
    chk("rst_in_release", {63'd0, ready_o}, 64'd0);
    ack_i = 1'b0;
    #3;
    rst_n_i = 1'b0;
    #1;
    chk("rst_async_outputs", {29'd0, ready_o, req_o, done_o, data_o}, {29'd0, 3'b100, 32'h0});
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done_o !== 1'b0 || req_o !== 1'b0 || ready_o !== 1'b1) bad++;
    end
    chk("rst_no_done", 64'(bad), 64'd0);

    // fresh transfer after reset, instant destination: done 6 edges after acceptance
    valid_i = 1'b1;
    data_i  = 32'hA5A5A5A5;
    step();
    valid_i = 1'b0;
    chk("fresh_accept", {31'd0, req_o, data_o}, {31'd0, 1'b1, 32'hA5A5A5A5});
    ack_i = 1'b1;
    step();
    step();
    step();
    chk("fresh_req_fall", {63'd0, req_o}, 64'd0);
    ack_i = 1'b0;
    step();
    step();
    chk("fresh_no_early_done", {62'd0, done_o, ready_o}, 64'd0);
    step();
    chk("fresh_done", {30'd0, done_o, ready_o, data_o}, {30'd0, 2'b11, 32'hA5A5A5A5});
    step();
    chk("fresh_done_drop", {62'd0, done_o, ready_o}, {62'd0, 2'b01});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
